// File: rtl/led_sequencer.sv
// Prescaled multi-mode LED pattern generator: binary up/down, Gray up, or a
// bouncing single-LED scanner, with enable, synchronous load and step/wrap strobes.
module led_sequencer #(
    parameter int WIDTH    = 8,
    parameter int CLOCK_HZ = 100000000,
    parameter int STEP_HZ  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             step,
    output logic             wrap
);
    localparam int DIV = CLOCK_HZ / STEP_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(WIDTH);

    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [SW-1:0] POS_TOP  = SW'(WIDTH - 1);
    localparam logic [SW-1:0] POS_TURN = SW'(WIDTH - 2);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;
    localparam logic [1:0] MODE_SCAN = 2'b11;

    logic [PW-1:0]    pre_reg, pre_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [SW-1:0]    pos_reg, pos_next;
    logic             dir_reg, dir_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             step_reg, step_next;
    logic             wrap_reg, wrap_next;

    logic             tick;
    logic [WIDTH-1:0] gray_disp;
    logic [WIDTH-1:0] scan_disp;

    assign tick = en && (pre_reg == PRE_LAST) && !load;

    always_comb begin
        pre_next  = pre_reg;
        cnt_next  = cnt_reg;
        pos_next  = pos_reg;
        dir_next  = dir_reg;
        wrap_next = 1'b0;
        step_next = tick;
        if (load) begin
            cnt_next = load_val;
            pos_next = '0;
            dir_next = 1'b0;
            pre_next = '0;
        end else if (tick) begin
            pre_next = '0;
            case (mode)
                MODE_UP, MODE_GRAY: begin
                    cnt_next  = cnt_reg + 1'b1;
                    wrap_next = &cnt_reg;
                end
                MODE_DOWN: begin
                    cnt_next  = cnt_reg - 1'b1;
                    wrap_next = (cnt_reg == '0);
                end
                default: begin
                    // The scanner reverses at either end and flags the bounce as a wrap.
                    if (!dir_reg) begin
                        if (pos_reg == POS_TOP) begin
                            pos_next  = POS_TURN;
                            dir_next  = 1'b1;
                            wrap_next = 1'b1;
                        end else begin
                            pos_next = pos_reg + 1'b1;
                        end
                    end else begin
                        if (pos_reg == '0) begin
                            pos_next  = SW'(1);
                            dir_next  = 1'b0;
                            wrap_next = 1'b1;
                        end else begin
                            pos_next = pos_reg - 1'b1;
                        end
                    end
                end
            endcase
        end else if (en) begin
            pre_next = pre_reg + 1'b1;
        end
    end

    // Display is derived from the post-edge state so out and step line up.
    assign gray_disp = cnt_next ^ (cnt_next >> 1);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_scan
            assign scan_disp[gi] = (pos_next == SW'(gi));
        end
    endgenerate

    always_comb begin
        out_next = cnt_next;
        case (mode)
            MODE_GRAY: out_next = gray_disp;
            MODE_SCAN: out_next = scan_disp;
            default:   out_next = cnt_next;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_reg  <= '0;
            cnt_reg  <= '0;
            pos_reg  <= '0;
            dir_reg  <= 1'b0;
            out_reg  <= '0;
            step_reg <= 1'b0;
            wrap_reg <= 1'b0;
        end else begin
            pre_reg  <= pre_next;
            cnt_reg  <= cnt_next;
            pos_reg  <= pos_next;
            dir_reg  <= dir_next;
            out_reg  <= out_next;
            step_reg <= step_next;
            wrap_reg <= wrap_next;
        end
    end

    assign out  = out_reg;
    assign step = step_reg;
    assign wrap = wrap_reg;
endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: a DIV=4 and a DIV=1 build share stimulus and
// are checked cycle by cycle against an arithmetic reference model.
module tb_led_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'h0;

    logic [3:0] out_a, out_b;
    logic       step_a, step_b, wrap_a, wrap_b;

    always #5 clk = ~clk;

    led_sequencer #(.WIDTH(4), .CLOCK_HZ(400), .STEP_HZ(100)) dut_a (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .out(out_a), .step(step_a), .wrap(wrap_a)
    );

    led_sequencer #(.WIDTH(4), .CLOCK_HZ(10), .STEP_HZ(10)) dut_b (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .out(out_b), .step(step_b), .wrap(wrap_b)
    );

    typedef struct {
        int pre;
        int cnt;
        int pos;
        int dir;
    } mstate_t;

    typedef struct {
        logic [3:0] out_a;
        logic       step_a;
        logic       wrap_a;
        logic [3:0] out_b;
        logic       step_b;
        logic       wrap_b;
    } exp_t;

    exp_t    sb[$];
    mstate_t ma, mb;
    int      vectors = 0;
    int      miscompares = 0;
    int      cycle = 0;
    logic [3:0] gray_tbl [16];

    // Reference model: spec rules with plain integer arithmetic and a Gray lookup table.
    task automatic model(input int div, inout mstate_t s, input bit rst, input bit e,
                         input bit ld, input logic [1:0] md, input logic [3:0] lv,
                         output logic [3:0] o, output logic st, output logic wr);
        st = 1'b0;
        wr = 1'b0;
        if (rst) begin
            s.pre = 0; s.cnt = 0; s.pos = 0; s.dir = 0;
            o = 4'h0;
            return;
        end
        if (ld) begin
            s.cnt = int'(lv); s.pos = 0; s.dir = 0; s.pre = 0;
        end else if (e) begin
            if (s.pre == div - 1) begin
                s.pre = 0;
                st = 1'b1;
                if (md == 2'd0 || md == 2'd2) begin
                    wr = (s.cnt == 15);
                    s.cnt = (s.cnt + 1) % 16;
                end else if (md == 2'd1) begin
                    wr = (s.cnt == 0);
                    s.cnt = (s.cnt + 15) % 16;
                end else if (s.dir == 0) begin
                    if (s.pos == 3) begin s.pos = 2; s.dir = 1; wr = 1'b1; end
                    else s.pos = s.pos + 1;
                end else begin
                    if (s.pos == 0) begin s.pos = 1; s.dir = 0; wr = 1'b1; end
                    else s.pos = s.pos - 1;
                end
            end else begin
                s.pre = s.pre + 1;
            end
        end
        case (md)
            2'd2:    o = gray_tbl[s.cnt];
            2'd3:    o = 4'(1 << s.pos);
            default: o = 4'(s.cnt);
        endcase
    endtask

    task automatic cyc(input bit rst, input bit e, input bit ld, input logic [1:0] md,
                       input logic [3:0] lv);
        exp_t x;
        @(negedge clk);
        reset = rst; en = e; load = ld; mode = md; load_val = lv;
        @(posedge clk);
        model(4, ma, rst, e, ld, md, lv, x.out_a, x.step_a, x.wrap_a);
        model(1, mb, rst, e, ld, md, lv, x.out_b, x.step_b, x.wrap_b);
        sb.push_back(x);
    endtask

    task automatic run(input logic [1:0] md, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, md, 4'h0);
    endtask

    // Monitor: every cycle the DUTs present out/step/wrap; compare against the queue head.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            cycle++;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                vectors++;
                if (out_a !== x.out_a || step_a !== x.step_a || wrap_a !== x.wrap_a) begin
                    miscompares++;
                    $display("FAIL div4 cyc=%0d got out=%h step=%b wrap=%b expected out=%h step=%b wrap=%b",
                             cycle, out_a, step_a, wrap_a, x.out_a, x.step_a, x.wrap_a);
                end
                vectors++;
                if (out_b !== x.out_b || step_b !== x.step_b || wrap_b !== x.wrap_b) begin
                    miscompares++;
                    $display("FAIL div1 cyc=%0d got out=%h step=%b wrap=%b expected out=%h step=%b wrap=%b",
                             cycle, out_b, step_b, wrap_b, x.out_b, x.step_b, x.wrap_b);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] gv [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        logic [1:0] rmode;
        gray_tbl = gv;
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};

        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
        run(2'd0, 70);                    // binary up through a full wrap
        cyc(1'b1, 1'b0, 1'b0, 2'd1, 4'h0);
        run(2'd1, 12);                    // binary down: F with wrap, then E
        cyc(1'b1, 1'b0, 1'b0, 2'd2, 4'h0);
        run(2'd2, 68);                    // Gray sequence
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 4'h0);
        run(2'd3, 40);                    // scanner bounces

        // Load on the edge the prescaler would tick, then drop en mid-period.
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
        while (ma.pre != 3) cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'h0);
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 4'hA);
        run(2'd0, 2);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        run(2'd0, 8);

        // Mode switches mid-period, then reset in the middle of a scan.
        run(2'd2, 5);
        run(2'd3, 9);
        run(2'd1, 6);
        run(2'd3, 7);
        cyc(1'b1, 1'b1, 1'b1, 2'd3, 4'h5);
        run(2'd3, 10);
        run(2'd0, 6);

        rmode = 2'd0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) rmode = 2'($urandom);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 39) == 0, rmode, 4'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending expected 0 pending", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
